instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/isa_pkg.sv | 34 +++
 rtl/instr_field_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants: opcodes, R-type funct codes and request kind codes.
// Common to the encoder and decoder sides.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JUMP  = 6'h02;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [3:0] {
        KindAdd = 4'd0,
        KindSub = 4'd1,
        KindAnd = 4'd2,
        KindOr  = 4'd3,
        KindSlt = 4'd4,
        KindLw  = 4'd5,
        KindSw  = 4'd6,
        KindBeq = 4'd7,
        KindJ   = 4'd8
    } kind_e;

    function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of request fields into a 32-bit instruction word.
// Kind 8 (J) is only encoded when INSTR_ENCODER_JUMP_EN is defined.
module instr_field_pack
    import isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        invalid
);

    always_comb begin
        word    = '0;
        invalid = 1'b0;
        case (kind)
            KindAdd: word = pack_rtype(rs, rt, rd, FUNCT_ADD);
            KindSub: word = pack_rtype(rs, rt, rd, FUNCT_SUB);
            KindAnd: word = pack_rtype(rs, rt, rd, FUNCT_AND);
            KindOr:  word = pack_rtype(rs, rt, rd, FUNCT_OR);
            KindSlt: word = pack_rtype(rs, rt, rd, FUNCT_SLT);
            KindLw:  word = {OP_LW, rs, rt, imm};
            KindSw:  word = {OP_SW, rs, rt, imm};
            KindBeq: word = {OP_BEQ, rs, rt, imm};
`ifdef INSTR_ENCODER_JUMP_EN
            KindJ:   word = {OP_JUMP, target};
`endif
            default: invalid = 1'b1;
        endcase
    end

`ifndef INSTR_ENCODER_JUMP_EN
    logic unused_target;
    assign unused_target = ^target;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: request handshake, write pointer and a single output register
// feeding instruction memory. Optional J support via INSTR_ENCODER_JUMP_EN.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_P = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0]              i_kind,
    input  logic [4:0]              i_rs,
    input  logic [4:0]              i_rt,
    input  logic [4:0]              i_rd,
    input  logic [15:0]             i_imm,
    input  logic [25:0]             i_target,
    input  logic                    i_addr_load,
    input  logic [ADDR_WIDTH_P-1:0] i_load_addr,
    output logic                    o_wr_valid,
    output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
    output logic [31:0]             o_wr_data,
    input  logic                    i_wr_ready,
    output logic                    o_err,
    output logic                    o_wrap
);

    logic [31:0]             word;
    logic                    invalid;
    logic                    accept;
    logic [ADDR_WIDTH_P-1:0] base;

    logic                    wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH_P-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]             wr_data_q, wr_data_d;
    logic [ADDR_WIDTH_P-1:0] ptr_q, ptr_d;
    logic                    err_q, err_d;
    logic                    wrap_q, wrap_d;

    instr_field_pack u_pack (
        .kind    (i_kind),
        .rs      (i_rs),
        .rt      (i_rt),
        .rd      (i_rd),
        .imm     (i_imm),
        .target  (i_target),
        .word    (word),
        .invalid (invalid)
    );

    assign o_ready = !wr_valid_q || i_wr_ready;
    assign accept  = i_valid && o_ready;
    // A same-cycle pointer load redirects the accepted request as well.
    assign base    = i_addr_load ? i_load_addr : ptr_q;

    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ptr_d      = base;
        err_d      = err_q;
        wrap_d     = wrap_q;

        if (wr_valid_q && i_wr_ready) begin
            wr_valid_d = 1'b0;
        end

        if (accept) begin
            if (invalid) begin
                err_d = 1'b1;
            end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = base;
                wr_data_d  = word;
                ptr_d      = base + ADDR_WIDTH_P'(1);
                if (base == {ADDR_WIDTH_P{1'b1}}) begin
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ptr_q      <= '0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ptr_q      <= ptr_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
        end
    end

    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_err      = err_q;
    assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a behavioural model.
module tb_instr_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [3:0]  i_kind = '0;
    logic [4:0]  i_rs = '0;
    logic [4:0]  i_rt = '0;
    logic [4:0]  i_rd = '0;
    logic [15:0] i_imm = '0;
    logic [25:0] i_target = '0;
    logic        i_addr_load = 1'b0;
    logic [7:0]  i_load_addr = '0;
    logic        o_wr_valid;
    logic [7:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        i_wr_ready = 1'b1;
    logic        o_err;
    logic        o_wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_WIDTH_P(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_kind      (i_kind),
        .i_rs        (i_rs),
        .i_rt        (i_rt),
        .i_rd        (i_rd),
        .i_imm       (i_imm),
        .i_target    (i_target),
        .i_addr_load (i_addr_load),
        .i_load_addr (i_load_addr),
        .o_wr_valid  (o_wr_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .i_wr_ready  (i_wr_ready),
        .o_err       (o_err),
        .o_wrap      (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference encoding from the instruction format tables; bit 32 flags a valid kind.
    function automatic logic [32:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int imm, input int tgt);
        int r;
        int funct;
        r = (rs << 21) + (rt << 16) + (rd << 11);
        case (kind)
            0: funct = 32'h20;
            1: funct = 32'h22;
            2: funct = 32'h24;
            3: funct = 32'h25;
            4: funct = 32'h2A;
            default: funct = -1;
        endcase
        if (funct >= 0) return {1'b1, 32'(r + funct)};
        case (kind)
            5: return {1'b1, 32'((32'h23 << 26) + (rs << 21) + (rt << 16) + imm)};
            6: return {1'b1, 32'((32'h2B << 26) + (rs << 21) + (rt << 16) + imm)};
            7: return {1'b1, 32'((32'h04 << 26) + (rs << 21) + (rt << 16) + imm)};
`ifdef INSTR_ENCODER_JUMP_EN
            8: return {1'b1, 32'((32'h02 << 26) + tgt)};
`endif
            default: return 33'd0;
        endcase
    endfunction

    // Behavioural model of the visible state.
    int          m_ptr = 0;
    logic        m_valid = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    logic        m_wrap = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        logic [32:0] enc;
        int          dest;
        logic        rdy;
        if (!i_rst_n) begin
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_addr  <= 0;
            m_data  <= '0;
            m_err   <= 1'b0;
            m_wrap  <= 1'b0;
        end else begin
            enc  = ref_encode(int'(i_kind), int'(i_rs), int'(i_rt), int'(i_rd),
                              int'(i_imm), int'(i_target));
            dest = i_addr_load ? int'(i_load_addr) : m_ptr;
            rdy  = !m_valid || i_wr_ready;
            if (m_valid && i_wr_ready) m_valid <= 1'b0;
            m_ptr <= dest;
            if (i_valid && rdy) begin
                if (!enc[32]) begin
                    m_err <= 1'b1;
                end else begin
                    m_valid <= 1'b1;
                    m_addr  <= dest;
                    m_data  <= enc[31:0];
                    m_ptr   <= (dest + 1) % 256;
                    if (dest == 255) m_wrap <= 1'b1;
                end
            end
        end
    end

    always @(negedge i_clk) begin
        check("ready", 32'(o_ready), 32'(!m_valid || i_wr_ready));
        check("wr_valid", 32'(o_wr_valid), 32'(m_valid));
        check("err", 32'(o_err), 32'(m_err));
        check("wrap", 32'(o_wrap), 32'(m_wrap));
        if (m_valid) begin
            check("wr_addr", 32'(o_wr_addr), 32'(m_addr));
            check("wr_data", o_wr_data, m_data);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        i_valid  = 1'b1;
        i_kind   = k;
        i_rs     = rs;
        i_rt     = rt;
        i_rd     = rd;
        i_imm    = imm;
        i_target = tgt;
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_addr_load = 1'b0;
        i_wr_ready  = 1'b1;
        tick();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_valid", 32'(o_wr_valid), 32'd0);
        check("rst_addr", 32'(o_wr_addr), 32'd0);
        check("rst_data", o_wr_data, 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_wrap", 32'(o_wrap), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);

        // ADD after reset
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        check("add_valid", 32'(o_wr_valid), 32'd1);
        check("add_addr", 32'(o_wr_addr), 32'd0);
        check("add_data", o_wr_data, 32'h0022_1820);

        // LW then BEQ back-to-back
        do_reset();
        req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        tick();
        check("lw_addr", 32'(o_wr_addr), 32'd0);
        check("lw_data", o_wr_data, 32'h8FA8_0004);
        req(4'd7, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0);
        tick();
        check("beq_valid", 32'(o_wr_valid), 32'd1);
        check("beq_addr", 32'(o_wr_addr), 32'd1);
        check("beq_data", o_wr_data, 32'h1085_FFFF);

        // J
        do_reset();
        req(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0100);
        tick();
`ifdef INSTR_ENCODER_JUMP_EN
        check("j_valid", 32'(o_wr_valid), 32'd1);
        check("j_data", o_wr_data, 32'h0800_0100);
`else
        check("j_valid", 32'(o_wr_valid), 32'd0);
        check("j_err", 32'(o_err), 32'd1);
`endif

        // SLT stalled for 3 cycles, then ADD accepted on release
        do_reset();
        i_wr_ready = 1'b0;
        req(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        req(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            check("slt_ready", 32'(o_ready), 32'd0);
            check("slt_valid", 32'(o_wr_valid), 32'd1);
            check("slt_addr", 32'(o_wr_addr), 32'd0);
            check("slt_data", o_wr_data, 32'h0022_182A);
            tick();
        end
        i_wr_ready = 1'b1;
        #1;
        check("release_ready", 32'(o_ready), 32'd1);
        tick();
        check("next_addr", 32'(o_wr_addr), 32'd1);
        check("next_data", o_wr_data, 32'h0085_3020);

        // Pointer load to 0xFF with SW, then wrap
        do_reset();
        i_addr_load = 1'b1;
        i_load_addr = 8'hFF;
        req(4'd6, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0);
        tick();
        i_addr_load = 1'b0;
        check("sw_addr", 32'(o_wr_addr), 32'hFF);
        check("sw_data", o_wr_data, 32'hAC22_0010);
        check("sw_wrap", 32'(o_wrap), 32'd1);
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        check("after_wrap_addr", 32'(o_wr_addr), 32'd0);

        // Invalid kind, then reset with a word pending
        do_reset();
        req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        req(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        check("inv_valid", 32'(o_wr_valid), 32'd0);
        check("inv_err", 32'(o_err), 32'd1);
        req(4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0);
        i_wr_ready = 1'b0;
        tick();
        check("inv_ptr", 32'(o_wr_addr), 32'd1);
        i_valid = 1'b0;
        #1;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_wr_valid), 32'd0);
        check("arst_addr", 32'(o_wr_addr), 32'd0);
        check("arst_data", o_wr_data, 32'd0);
        check("arst_err", 32'(o_err), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd1);
        tick();
        i_rst_n    = 1'b1;
        i_wr_ready = 1'b1;
        tick();
        check("no_replay", 32'(o_wr_valid), 32'd0);

        // Randomized traffic checked by the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_valid     = ($urandom_range(0, 9) < 7);
            i_kind      = 4'($urandom_range(0, 15));
            i_rs        = 5'($urandom);
            i_rt        = 5'($urandom);
            i_rd        = 5'($urandom);
            i_imm       = 16'($urandom);
            i_target    = 26'($urandom);
            i_wr_ready  = ($urandom_range(0, 9) < 7);
            i_addr_load = ($urandom_range(0, 19) == 0);
            i_load_addr = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'($urandom);
            if (c == 1500) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
